beta_if_prefetch_stage: RTL and testbench

Parametrised successor of the instruction fetch stage. It generates sequential fetch addresses itself, keeps up to `FifoDepth` requests in flight on the instruction memory port, and buffers returned instructions together with their PCs in a prefetch FIFO. It supports a redirect (branch/exception) that flushes buffered and in-flight instructions. It sits between the instruction memory and the decode stage.

---
 rtl/beta_if_stage_pkg.sv | 32 +++
 rtl/beta_prefetch_fifo.sv | 98 +++++++++
 rtl/beta_if_prefetch_stage.sv | 160 ++++++++++++++++
 tb/tb_beta_if_prefetch_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/beta_if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : beta_if_stage_pkg
// Description : Shared constants and types for the beta prefetching
//               instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package beta_if_stage_pkg;

    // Size of one instruction word in bytes; also the sequential PC step.
    localparam int unsigned INSTR_BYTES = 4;

    // Fetch PC used after reset when the instantiating level does not override it.
    localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

    // Address/instruction width of the default build.
    localparam int unsigned XLEN_DEFAULT = 32;

    // One prefetch FIFO entry of the default build: instruction word and its PC.
    // The stage re-declares the same layout at its own DataWidth.
    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] instr;
        logic [XLEN_DEFAULT-1:0] pc;
    } if_fifo_entry_t;

    // Counter width able to hold the values 0..depth inclusive.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/beta_prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : beta_prefetch_fifo
// Description : Synchronous shifting FIFO. Entry 0 is always the head, so the
//               head data comes straight out of a register. Flush empties the
//               FIFO and wins over push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module beta_prefetch_fifo
    import beta_if_stage_pkg::*;
#(
    parameter int unsigned Width = 64,
    parameter int unsigned Depth = 4
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic                           flush_i,
    input  logic [Width-1:0]               data_i,
    output logic [Width-1:0]               head_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(Depth+1)-1:0]     count_o
);

    localparam int unsigned c_CNT_W = occ_width(Depth);
    localparam int          c_DEPTH = int'(Depth);

    logic [Width-1:0]   r_mem [Depth];
    logic [Width-1:0]   w_shift [Depth];
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_wr_idx;
    logic               w_full;
    logic               w_empty;
    logic               w_do_pop;
    logic               w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_CNT_W'(Depth));
    assign w_do_pop  = pop_i && !w_empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign w_do_push = push_i && (!w_full || w_do_pop);
    // The new entry lands just above the last valid entry after any shift.
    assign w_wr_idx  = w_do_pop ? (r_count - c_CNT_W'(1)) : r_count;

    // Value each entry takes when the FIFO shifts towards the head.
    always_comb begin
        for (int i = 0; i < c_DEPTH; i++) begin
            w_shift[i] = r_mem[i];
        end
        for (int i = 0; i < c_DEPTH - 1; i++) begin
            w_shift[i] = r_mem[i + 1];
        end
    end

    // Entry storage: write the pushed word, otherwise shift on pop.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!flush_i) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                if (w_do_push && (w_wr_idx == c_CNT_W'(i))) begin
                    r_mem[i] <= data_i;
                end else if (w_do_pop) begin
                    r_mem[i] <= w_shift[i];
                end
            end
        end
    end

    // Occupancy: flush clears it, push and pop together leave it unchanged.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_count <= '0;
        end else if (flush_i) begin
            r_count <= '0;
        end else if (w_do_push && !w_do_pop) begin
            r_count <= r_count + c_CNT_W'(1);
        end else if (!w_do_push && w_do_pop) begin
            r_count <= r_count - c_CNT_W'(1);
        end
    end

    // The producer's credit scheme must never push into a full FIFO.
    a_no_push_when_full : assert property (
        @(posedge clk_i) disable iff (!rstn_i) !(push_i && !flush_i && w_full)
    );

    assign head_o  = r_mem[0];
    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/beta_if_prefetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : beta_if_prefetch_stage
// Description : Prefetching instruction fetch stage. Issues sequential word
//               fetches with up to FifoDepth requests in flight, buffers the
//               returned instructions with their PCs, and flushes buffered and
//               in-flight instructions on a redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module beta_if_prefetch_stage
    import beta_if_stage_pkg::*;
#(
    parameter int unsigned          DataWidth = 32,
    parameter int unsigned          FifoDepth = 4,
    parameter logic [DataWidth-1:0] BootAddr  = DataWidth'(BOOT_ADDR_DEFAULT)
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic                            if_fetch_en_i,
    output logic                            if_instr_req_o,
    output logic [DataWidth-1:0]            if_instr_addr_o,
    input  logic                            if_instr_ready_i,
    input  logic                            if_instr_valid_i,
    input  logic [DataWidth-1:0]            if_instr_rdata_i,
    input  logic                            if_redirect_i,
    input  logic [DataWidth-1:0]            if_redirect_pc_i,
    output logic                            if_new_instr_o,
    output logic [DataWidth-1:0]            if_instr_o,
    output logic [DataWidth-1:0]            if_curr_pc_o,
    input  logic                            if_id_ready_i,
    output logic [$clog2(FifoDepth+1)-1:0]  if_fifo_count_o,
    output logic                            if_stage_busy_o
);

    localparam int unsigned          c_CNT_W      = occ_width(FifoDepth);
    localparam int unsigned          c_SUM_W      = c_CNT_W + 1;
    localparam logic [DataWidth-1:0] c_PC_STEP    = DataWidth'(INSTR_BYTES);
    localparam logic [DataWidth-1:0] c_ALIGN_MASK = ~DataWidth'(INSTR_BYTES - 1);

    // FIFO entry at this instance's width.
    typedef struct packed {
        logic [DataWidth-1:0] instr;
        logic [DataWidth-1:0] pc;
    } stage_entry_t;

    logic [DataWidth-1:0] r_fetch_pc;
    logic [DataWidth-1:0] r_resp_pc;
    logic [c_CNT_W-1:0]   r_outstanding;
    logic [c_CNT_W-1:0]   r_discard;

    logic [c_CNT_W-1:0]   w_fifo_count;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_fifo_push;
    logic                 w_fifo_pop;
    stage_entry_t         w_push_entry;
    stage_entry_t         w_head_entry;

    logic [c_SUM_W-1:0]   w_inflight;
    logic                 w_req;
    logic                 w_issue;
    logic                 w_resp;
    logic                 w_keep;
    logic [DataWidth-1:0] w_redirect_pc;

    // Buffered plus in-flight instructions; a new request needs a free slot
    // for its eventual response so a push can never find the FIFO full.
    assign w_inflight = c_SUM_W'(w_fifo_count) + c_SUM_W'(r_outstanding);

    // Request is held low in reset and in the redirect cycle.
    assign w_req = rstn_i && if_fetch_en_i && !if_redirect_i && !w_fifo_full
                   && (w_inflight < c_SUM_W'(FifoDepth));
    assign w_issue = w_req && if_instr_ready_i;

    // A response with nothing outstanding is not expected; ignore it.
    assign w_resp = if_instr_valid_i && (r_outstanding != '0);

    // Keep a response only when no stale responses remain and no redirect
    // is flushing the stage this cycle.
    assign w_keep = w_resp && !if_redirect_i && (r_discard == '0);

    assign w_redirect_pc = if_redirect_pc_i & c_ALIGN_MASK;

    assign w_fifo_push        = w_keep;
    assign w_fifo_pop         = !w_fifo_empty && if_id_ready_i && !if_redirect_i;
    assign w_push_entry.instr = if_instr_rdata_i;
    assign w_push_entry.pc    = r_resp_pc;

    beta_prefetch_fifo #(
        .Width ($bits(stage_entry_t)),
        .Depth (FifoDepth)
    ) u_prefetch_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (w_fifo_push),
        .pop_i   (w_fifo_pop),
        .flush_i (if_redirect_i),
        .data_i  (w_push_entry),
        .head_o  (w_head_entry),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    // Next request address: restart at the redirect PC, else step on acceptance.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_fetch_pc <= BootAddr;
        end else if (if_redirect_i) begin
            r_fetch_pc <= w_redirect_pc;
        end else if (w_issue) begin
            r_fetch_pc <= r_fetch_pc + c_PC_STEP;
        end
    end

    // PC tagged onto the next kept response; follows the same sequence as
    // the requests but only advances when data is actually buffered.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_resp_pc <= BootAddr;
        end else if (if_redirect_i) begin
            r_resp_pc <= w_redirect_pc;
        end else if (w_keep) begin
            r_resp_pc <= r_resp_pc + c_PC_STEP;
        end
    end

    // Accepted requests still waiting for their response, stale ones included.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_outstanding <= '0;
        end else if (w_issue && !w_resp) begin
            r_outstanding <= r_outstanding + c_CNT_W'(1);
        end else if (!w_issue && w_resp) begin
            r_outstanding <= r_outstanding - c_CNT_W'(1);
        end
    end

    // Stale responses to drop: everything in flight at a redirect, minus the
    // response that arrives (and is dropped) in the redirect cycle itself.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_discard <= '0;
        end else if (if_redirect_i) begin
            r_discard <= r_outstanding - (w_resp ? c_CNT_W'(1) : c_CNT_W'(0));
        end else if (w_resp && (r_discard != '0)) begin
            r_discard <= r_discard - c_CNT_W'(1);
        end
    end

    assign if_instr_req_o  = w_req;
    assign if_instr_addr_o = r_fetch_pc;
    assign if_new_instr_o  = !w_fifo_empty;
    assign if_instr_o      = w_head_entry.instr;
    assign if_curr_pc_o    = w_head_entry.pc;
    assign if_fifo_count_o = w_fifo_count;
    assign if_stage_busy_o = (r_outstanding != '0);

endmodule
`default_nettype wire

// File: tb/tb_beta_if_prefetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_beta_if_prefetch_stage
// Description : Randomised self-checking bench for beta_if_prefetch_stage
//               with an epoch-tagged memory/FIFO reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_beta_if_prefetch_stage;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BOOT  = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        if_fetch_en_i;
    logic        if_instr_req_o;
    logic [31:0] if_instr_addr_o;
    logic        if_instr_ready_i;
    logic        if_instr_valid_i;
    logic [31:0] if_instr_rdata_i;
    logic        if_redirect_i;
    logic [31:0] if_redirect_pc_i;
    logic        if_new_instr_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_curr_pc_o;
    logic        if_id_ready_i;
    logic [2:0]  if_fifo_count_o;
    logic        if_stage_busy_o;

    always #5 clk_i = ~clk_i;

    beta_if_prefetch_stage #(
        .DataWidth (DW),
        .FifoDepth (DEPTH),
        .BootAddr  (BOOT)
    ) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .if_fetch_en_i    (if_fetch_en_i),
        .if_instr_req_o   (if_instr_req_o),
        .if_instr_addr_o  (if_instr_addr_o),
        .if_instr_ready_i (if_instr_ready_i),
        .if_instr_valid_i (if_instr_valid_i),
        .if_instr_rdata_i (if_instr_rdata_i),
        .if_redirect_i    (if_redirect_i),
        .if_redirect_pc_i (if_redirect_pc_i),
        .if_new_instr_o   (if_new_instr_o),
        .if_instr_o       (if_instr_o),
        .if_curr_pc_o     (if_curr_pc_o),
        .if_id_ready_i    (if_id_ready_i),
        .if_fifo_count_o  (if_fifo_count_o),
        .if_stage_busy_o  (if_stage_busy_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: every accepted request carries the epoch it was issued
    // in; a redirect starts a new epoch, and only current-epoch responses are
    // delivered, each with the address it was fetched from as its PC.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] epoch;
    } req_t;

    req_t        mem_q[$];
    logic [31:0] m_pc_q[$];
    logic [31:0] m_fetch;
    logic [31:0] m_epoch = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic pct(input int p);
        return ($urandom_range(99) < p);
    endfunction

    function automatic logic [31:0] pick_pc();
        logic [31:0] v;
        case ($urandom_range(3))
            0:       v = $urandom;
            1:       v = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            2:       v = 32'h0000_0100 | 32'($urandom_range(3));
            default: v = 32'($urandom_range(255));
        endcase
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(if_instr_req_o),  32'd0);
        check({tag, "_new"},   32'(if_new_instr_o),  32'd0);
        check({tag, "_busy"},  32'(if_stage_busy_o), 32'd0);
        check({tag, "_count"}, 32'(if_fifo_count_o), 32'd0);
        check({tag, "_instr"}, if_instr_o,            32'd0);
        check({tag, "_pc"},    if_curr_pc_o,          32'd0);
    endtask

    // One clock cycle: drive inputs at the falling edge, compare all outputs
    // against the model, then advance the model as the rising edge will.
    task automatic cycle(input int p_en, input int p_rdy, input int p_val, input int p_idr,
                         input int p_redir, input bit use_pc = 1'b0,
                         input logic [31:0] rpc = 32'd0);
        bit   m_req, acc, keep, pop;
        req_t f;
        @(negedge clk_i);
        if_fetch_en_i    = pct(p_en);
        if_instr_ready_i = pct(p_rdy);
        if_id_ready_i    = pct(p_idr);
        if_redirect_i    = pct(p_redir);
        if_redirect_pc_i = use_pc ? rpc : pick_pc();
        if_instr_valid_i = (mem_q.size() != 0) && pct(p_val);
        if_instr_rdata_i = if_instr_valid_i ? word_of(mem_q[0].addr) : $urandom;
        #1;
        m_req = if_fetch_en_i && !if_redirect_i && ((m_pc_q.size() + mem_q.size()) < DEPTH);
        check("req", 32'(if_instr_req_o), 32'(m_req));
        if (m_req) check("addr", if_instr_addr_o, m_fetch);
        check("new_instr", 32'(if_new_instr_o), 32'(m_pc_q.size() != 0));
        if (m_pc_q.size() != 0) begin
            check("curr_pc", if_curr_pc_o, m_pc_q[0]);
            check("instr", if_instr_o, word_of(m_pc_q[0]));
        end
        check("count", 32'(if_fifo_count_o), 32'(m_pc_q.size()));
        check("busy", 32'(if_stage_busy_o), 32'(mem_q.size() != 0));

        acc  = m_req && if_instr_ready_i;
        keep = 1'b0;
        f    = '0;
        if (if_instr_valid_i) begin
            f    = mem_q.pop_front();
            keep = (f.epoch == m_epoch) && !if_redirect_i;
        end
        pop = (m_pc_q.size() != 0) && if_id_ready_i && !if_redirect_i;
        if (if_redirect_i) begin
            m_pc_q.delete();
            m_epoch++;
            m_fetch = if_redirect_pc_i & ~32'h3;
        end else begin
            if (pop)  void'(m_pc_q.pop_front());
            if (keep) m_pc_q.push_back(f.addr);
            if (acc) begin
                mem_q.push_back({m_fetch, m_epoch});
                m_fetch = m_fetch + 32'd4;
            end
        end
    endtask

    // Reset asserted between edges with fetch enabled; outputs must clear at once.
    task automatic async_reset(input string tag);
        @(negedge clk_i);
        if_fetch_en_i    = 1'b1;
        if_instr_ready_i = 1'b1;
        if_instr_valid_i = 1'b0;
        if_redirect_i    = 1'b0;
        #2 rstn_i = 1'b0;
        #1 check_reset_outputs(tag);
        @(posedge clk_i);
        #1 check_reset_outputs({tag, "_held"});
        @(negedge clk_i);
        if_fetch_en_i = 1'b0;
        rstn_i        = 1'b1;
        m_pc_q.delete();
        mem_q.delete();
        m_fetch = BOOT;
        m_epoch++;
    endtask

    initial begin
        if_fetch_en_i    = 1'b1;
        if_instr_ready_i = 1'b0;
        if_instr_valid_i = 1'b0;
        if_instr_rdata_i = 32'd0;
        if_redirect_i    = 1'b0;
        if_redirect_pc_i = 32'd0;
        if_id_ready_i    = 1'b0;
        rstn_i           = 1'b1;
        m_fetch          = BOOT;
        #1 rstn_i = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk_i);
        #1 check_reset_outputs("reset_held");
        @(negedge clk_i);
        if_fetch_en_i = 1'b0;
        rstn_i        = 1'b1;

        // Streaming: zero-wait memory, decode always ready.
        repeat (30) cycle(100, 100, 100, 100, 0);

        // Backpressure: decode stalls until the FIFO fills, then one pop.
        repeat (12) cycle(100, 100, 100, 0, 0);
        cycle(100, 100, 100, 100, 0);
        repeat (6) cycle(100, 100, 100, 0, 0);

        // Redirect with requests in flight and a slow memory.
        repeat (8) cycle(100, 100, 100, 100, 0);
        repeat (3) cycle(100, 100, 0, 100, 0);
        cycle(100, 100, 0, 100, 100, 1'b1, 32'h0000_0100);
        repeat (10) cycle(100, 100, 60, 100, 0);

        // Redirect with a response and a pop in the same cycle.
        repeat (6) cycle(100, 100, 100, 100, 0);
        cycle(100, 100, 100, 100, 100, 1'b1, 32'h0000_0200);
        repeat (8) cycle(100, 100, 100, 100, 0);

        // PC wrap at the top of the address space.
        cycle(100, 100, 100, 100, 100, 1'b1, 32'hFFFF_FFFC);
        repeat (12) cycle(100, 100, 100, 100, 0);

        // Redirect while fetch is disabled, then drain with fetch off.
        cycle(0, 100, 100, 100, 100, 1'b1, 32'h0000_0043);
        repeat (6) cycle(0, 100, 100, 100, 0);
        repeat (8) cycle(100, 100, 100, 100, 0);

        // Asynchronous reset in the middle of a burst.
        repeat (5) cycle(100, 100, 50, 50, 0);
        async_reset("mid_reset");
        repeat (10) cycle(100, 100, 100, 100, 0);

        // Randomised traffic in blocks with varying behaviour.
        for (int b = 0; b < 80; b++) begin
            int pe, pr, pv, pi, pd;
            pe = $urandom_range(100);
            pr = $urandom_range(100);
            pv = $urandom_range(100);
            pi = $urandom_range(100);
            pd = $urandom_range(8);
            repeat (50) cycle(pe, pr, pv, pi, pd);
            if (b == 40) async_reset("rand_reset");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
